// File: rtl/serv_alu_seq.sv
// serv_alu_seq: operand sequencer and result collector for a bit-serial ALU.
// Accepts a 32-bit operand pair, streams it to the ALU W bits per cycle
// (LSB slice first), reassembles the returned result slices into a 32-bit
// word and presents it, with the final compare flag, on a response port.
module serv_alu_seq #(
    parameter int W = 1,
    parameter int B = W - 1
) (
    input  logic         clk,
    input  logic         i_rst_n,
    // request port
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [31:0]  i_rs1,
    input  logic [31:0]  i_op_b,
    // ALU side
    output logic         o_en,
    output logic         o_cnt0,
    output logic         o_last,
    output logic [B:0]   o_rs1,
    output logic [B:0]   o_op_b,
    input  logic [B:0]   i_rd,
    input  logic         i_cmp,
    // response port
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [31:0]  o_rd,
    output logic         o_cmp
);

    localparam int N  = 32 / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [31:0]     rs1_reg;
    logic [31:0]     op_b_reg;
    logic [31:0]     acc_reg;
    logic [31:0]     rd_reg;
    logic            cmp_reg;

    logic            run;
    logic            accept;
    logic            last_slice;
    logic [W+31:0]   acc_cat;
    logic [31:0]     acc_shift;

    assign run        = (state_reg == RUN);
    assign accept     = (state_reg == IDLE) && i_req_valid;
    assign last_slice = (cnt_reg == CW'(N - 1));

    // New result slice enters at the top; everything already collected moves
    // down by one slice. After N slices the first one sits at bits [W-1:0].
    assign acc_cat   = {i_rd, acc_reg};
    assign acc_shift = 32'(acc_cat >> W);

    // Next-state and slice-counter logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (i_req_valid) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                cnt_next = cnt_reg + CW'(1);
                if (last_slice) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end
            end
            DONE: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and slice-counter registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Operand shift registers: loaded on accept, shifted right one slice per RUN cycle
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rs1_reg  <= '0;
            op_b_reg <= '0;
        end else if (accept) begin
            rs1_reg  <= i_rs1;
            op_b_reg <= i_op_b;
        end else if (run) begin
            rs1_reg  <= rs1_reg >> W;
            op_b_reg <= op_b_reg >> W;
        end
    end

    // Result collection; the presented word and flag only change at completion
    // so the response stays stable through DONE and the following IDLE.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_reg <= '0;
            rd_reg  <= '0;
            cmp_reg <= 1'b0;
        end else if (run) begin
            acc_reg <= acc_shift;
            if (last_slice) begin
                rd_reg  <= acc_shift;
                cmp_reg <= i_cmp;
            end
        end
    end

    // Operand slices are forced to zero whenever the ALU is not enabled
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_slice
            assign o_rs1[gi]  = run & rs1_reg[gi];
            assign o_op_b[gi] = run & op_b_reg[gi];
        end
    endgenerate

    assign o_en        = run;
    assign o_cnt0      = run && (cnt_reg == '0);
    assign o_last      = run && last_slice;
    assign o_req_ready = (state_reg == IDLE) && i_rst_n;
    assign o_rsp_valid = (state_reg == DONE);
    assign o_rd        = rd_reg;
    assign o_cmp       = cmp_reg;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Directed testbench for serv_alu_seq: three instances (W=1, 4, 32), each
// driving a small bit-serial add/sub ALU model with an equality compare.
module tb_serv_alu_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        sub;

    logic        req_valid [3];
    logic        rsp_ready [3];
    logic        req_ready [3];
    logic        en_o      [3];
    logic        cnt0_o    [3];
    logic        last_o    [3];
    logic        rsp_valid [3];
    logic        cmp_o     [3];
    logic [31:0] rd_o      [3];
    logic [31:0] rs1_o     [3];
    logic [31:0] opb_o     [3];

    int vectors;
    int miscompares;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int WL = (gi == 0) ? 1 : (gi == 1) ? 4 : 32;
            logic [WL-1:0] s_rs1, s_opb, s_rd;
            logic [WL:0]   sum;
            logic          carry_reg, eq_reg, s_cmp;

            // bit-serial add/sub: carry preloaded from sub while the ALU is idle
            always_comb begin
                sum   = {1'b0, s_rs1} + {1'b0, (sub ? ~s_opb : s_opb)} + {{WL{1'b0}}, carry_reg};
                s_rd  = sum[WL-1:0];
                s_cmp = (cnt0_o[gi] ? 1'b1 : eq_reg) & (s_rd == '0);
            end

            always_ff @(posedge clk) begin
                carry_reg <= en_o[gi] ? sum[WL] : sub;
                if (en_o[gi]) eq_reg <= s_cmp;
            end

            assign rs1_o[gi] = 32'(s_rs1);
            assign opb_o[gi] = 32'(s_opb);

            serv_alu_seq #(.W(WL)) u_dut (
                .clk         (clk),
                .i_rst_n     (rst_n),
                .i_req_valid (req_valid[gi]),
                .o_req_ready (req_ready[gi]),
                .i_rs1       (a_in),
                .i_op_b      (b_in),
                .o_en        (en_o[gi]),
                .o_cnt0      (cnt0_o[gi]),
                .o_last      (last_o[gi]),
                .o_rs1       (s_rs1),
                .o_op_b      (s_opb),
                .i_rd        (s_rd),
                .i_cmp       (s_cmp),
                .o_rsp_valid (rsp_valid[gi]),
                .i_rsp_ready (rsp_ready[gi]),
                .o_rd        (rd_o[gi]),
                .o_cmp       (cmp_o[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nsl(input int idx);
        return (idx == 0) ? 32 : (idx == 1) ? 8 : 1;
    endfunction

    function automatic logic [31:0] slc(input logic [31:0] v, input int w, input int k);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        return (v >> (w * k)) & m;
    endfunction

    task automatic check_reset_outputs(input int idx);
        check("rst_en",        32'(en_o[idx]),      32'd0);
        check("rst_cnt0",      32'(cnt0_o[idx]),    32'd0);
        check("rst_last",      32'(last_o[idx]),    32'd0);
        check("rst_rs1",       rs1_o[idx],          32'd0);
        check("rst_opb",       opb_o[idx],          32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[idx]), 32'd0);
        check("rst_rd",        rd_o[idx],           32'd0);
        check("rst_cmp",       32'(cmp_o[idx]),     32'd0);
    endtask

    // One full operation on instance idx, checking every cycle of its timeline.
    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_rd, input logic exp_cmp,
                         input int done_wait, input bit keep_valid, output int acc_cyc);
        int n, w, guard;
        n = nsl(idx);
        w = 32 / n;
        guard = 0;
        while (req_ready[idx] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", 32'(req_ready[idx]), 32'd1);
        a_in = a;
        b_in = b;
        sub  = s;
        req_valid[idx] = 1'b1;
        rsp_ready[idx] = (done_wait == 0);
        acc_cyc = cyc;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!keep_valid) req_valid[idx] = 1'b0;
                a_in = ~a;
                b_in = ~b;
            end
            check("run_en",    32'(en_o[idx]),      32'd1);
            check("run_cnt0",  32'(cnt0_o[idx]),    32'(c == 1));
            check("run_last",  32'(last_o[idx]),    32'(c == n));
            check("run_valid", 32'(rsp_valid[idx]), 32'd0);
            check("run_ready", 32'(req_ready[idx]), 32'd0);
            check("run_rs1",   rs1_o[idx],          slc(a, w, c - 1));
            check("run_opb",   opb_o[idx],          slc(b, w, c - 1));
        end
        @(negedge clk);
        check("done_valid", 32'(rsp_valid[idx]), 32'd1);
        check("done_en",    32'(en_o[idx]),      32'd0);
        check("done_ready", 32'(req_ready[idx]), 32'd0);
        check("done_rd",    rd_o[idx],           exp_rd);
        check("done_cmp",   32'(cmp_o[idx]),     32'(exp_cmp));
        for (int d = 0; d < done_wait; d++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid[idx]), 32'd1);
            check("bp_ready", 32'(req_ready[idx]), 32'd0);
            check("bp_rd",    rd_o[idx],           exp_rd);
            check("bp_cmp",   32'(cmp_o[idx]),     32'(exp_cmp));
        end
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        check("idle_valid", 32'(rsp_valid[idx]), 32'd0);
        check("idle_en",    32'(en_o[idx]),      32'd0);
        check("idle_ready", 32'(req_ready[idx]), 32'd1);
        check("idle_rd",    rd_o[idx],           exp_rd);
        check("idle_cmp",   32'(cmp_o[idx]),     32'(exp_cmp));
        $display("op idx=%0d a=%08h b=%08h sub=%0b rd=%08h cmp=%0b", idx, a, b, s, rd_o[idx], cmp_o[idx]);
    endtask

    initial begin
        int t0, t1, tx;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        a_in        = '0;
        b_in        = '0;
        sub         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_reset_outputs(i);
            check("rst_ready", 32'(req_ready[i]), 32'd1);
        end

        // W=1 add and subtract/equality
        do_op(0, 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 0, 1'b0, tx);
        do_op(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'd0, 1'b1, 0, 1'b0, tx);
        do_op(0, 32'h1234_5679, 32'h1234_5678, 1'b1, 32'd1, 1'b0, 0, 1'b0, tx);

        // W=4 add with full carry ripple, W=32 single-slice add and sub
        do_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 0, 1'b0, tx);
        do_op(2, 32'h0000_1234, 32'd1, 1'b0, 32'h0000_1235, 1'b0, 0, 1'b0, tx);
        do_op(2, 32'h0000_0010, 32'h0000_0010, 1'b1, 32'd0, 1'b1, 0, 1'b0, tx);

        // backpressure with a request held through RUN and DONE
        do_op(0, 32'd100, 32'd23, 1'b0, 32'd123, 1'b0, 10, 1'b1, tx);

        // back-to-back with request held and response always ready
        do_op(0, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 0, 1'b1, t0);
        do_op(0, 32'd40, 32'd2, 1'b0, 32'd42, 1'b0, 0, 1'b0, t1);
        check("b2b_period", 32'(t1 - t0), 32'd34);

        // reset in the middle of a run at k=10
        while (req_ready[0] !== 1'b1) @(negedge clk);
        a_in = 32'hAAAA_5555;
        b_in = 32'h0F0F_F0F0;
        sub  = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_en", 32'(en_o[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready[0]), 32'd1);
        do_op(0, 32'd7, 32'd9, 1'b0, 32'd16, 1'b0, 0, 1'b0, tx);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
